// File: rtl/thermostat_pkg.sv
// ---------------------------------------------------------------------------
// thermostat_pkg : shared encodings, widths and the setpoint step helper
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package thermostat_pkg;

  localparam int TEMP_W    = 8;
  localparam int AVG_DEPTH = 4;
  localparam int SUM_W     = 10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAT = 2'd1;
  localparam logic [1:0] COOL = 2'd2;

  // Simultaneous up/down presses cancel; the result never leaves [lo, hi].
  function automatic logic [TEMP_W-1:0] sp_step(
    input logic [TEMP_W-1:0] sp,
    input logic              inc,
    input logic              dec,
    input logic [TEMP_W-1:0] lo,
    input logic [TEMP_W-1:0] hi
  );
    sp_step = sp;
    if (inc && !dec && (sp < hi))
      sp_step = sp + TEMP_W'(1);
    else if (dec && !inc && (sp > lo))
      sp_step = sp - TEMP_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/thermostat_ctrl_avg4.sv
// ---------------------------------------------------------------------------
// temp_avg4 : 4-sample moving average of the sensor reading, updated per tick
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module temp_avg4
  import thermostat_pkg::*;
(
  input  logic              clk_200kHz,
  input  logic              reset,
  input  logic              tick,
  input  logic [TEMP_W-1:0] temp_data,
  output logic [TEMP_W-1:0] avg_temp,
  output logic              avg_valid
);

  logic [TEMP_W-1:0] r_buf [AVG_DEPTH];
  logic [2:0]        r_fill;
  logic [2:0]        w_fill_nxt;
  logic [SUM_W-1:0]  w_sum;

  // Sum of the window as it will be after this tick's shift, so the average
  // is registered on the same edge that captures the new sample.
  always_comb begin
    w_sum = SUM_W'(temp_data);
    for (int i = 0; i < AVG_DEPTH - 1; i++)
      w_sum = w_sum + SUM_W'(r_buf[i]);
    w_fill_nxt = (r_fill == 3'(AVG_DEPTH)) ? r_fill : r_fill + 3'd1;
  end

  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < AVG_DEPTH; i++)
        r_buf[i] <= '0;
      r_fill    <= '0;
      avg_temp  <= '0;
      avg_valid <= 1'b0;
    end else if (tick) begin
      r_buf[0] <= temp_data;
      for (int i = 1; i < AVG_DEPTH; i++)
        r_buf[i] <= r_buf[i-1];
      r_fill <= w_fill_nxt;
      if (w_fill_nxt == 3'(AVG_DEPTH)) begin
        avg_temp  <= TEMP_W'(w_sum >> 2);
        avg_valid <= 1'b1;
      end else begin
        avg_temp  <= '0;
        avg_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/thermostat_ctrl.sv
// ---------------------------------------------------------------------------
// thermostat_ctrl : sample tick, setpoint buttons and heat/cool hysteresis FSM
//                   optional over/under-temperature alarm: THERMO_ALARM_EN
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module thermostat_ctrl
  import thermostat_pkg::*;
#(
  parameter int SAMPLE_DIV = 2000,
  parameter int HYST       = 2,
  parameter int MIN_DWELL  = 50,
  parameter int SP_DEFAULT = 22,
  parameter int SP_MIN     = 10,
  parameter int SP_MAX     = 35
`ifdef THERMO_ALARM_EN
  ,
  parameter int ALARM_LO   = 5,
  parameter int ALARM_HI   = 45
`endif
) (
  input  logic              clk_200kHz,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp_data,
  input  logic              btn_up,
  input  logic              btn_dn,
  output logic [TEMP_W-1:0] setpoint,
  output logic [TEMP_W-1:0] avg_temp,
  output logic              avg_valid,
  output logic              heat_on,
  output logic              cool_on,
  output logic              alarm
);

  localparam int CNT_W = (SAMPLE_DIV < 2) ? 1 : $clog2(SAMPLE_DIV);
  localparam int DW_W  = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic             r_eval;
  logic [2:0]       r_up_sync;
  logic [2:0]       r_dn_sync;
  logic             w_up_rise;
  logic             w_dn_rise;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [DW_W-1:0]  r_dwell;
  logic [8:0]       w_avg9;
  logic [8:0]       w_sp9;
  logic             w_alarm_cond;

  assign w_tick = (r_tick_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_eval     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      r_eval     <= w_tick;
    end
  end

  temp_avg4 u_avg (
    .clk_200kHz (clk_200kHz),
    .reset      (reset),
    .tick       (w_tick),
    .temp_data  (temp_data),
    .avg_temp   (avg_temp),
    .avg_valid  (avg_valid)
  );

  // Bit 0 is the first synchronizer stage; bits 1/2 feed the edge detector.
  assign w_up_rise = r_up_sync[1] & ~r_up_sync[2];
  assign w_dn_rise = r_dn_sync[1] & ~r_dn_sync[2];

  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      r_up_sync <= '0;
      r_dn_sync <= '0;
      setpoint  <= TEMP_W'(SP_DEFAULT);
    end else begin
      r_up_sync <= {r_up_sync[1:0], btn_up};
      r_dn_sync <= {r_dn_sync[1:0], btn_dn};
      setpoint  <= sp_step(setpoint, w_up_rise, w_dn_rise,
                           TEMP_W'(SP_MIN), TEMP_W'(SP_MAX));
    end
  end

  assign w_avg9 = {1'b0, avg_temp};
  assign w_sp9  = {1'b0, setpoint};

`ifdef THERMO_ALARM_EN
  logic r_alarm;

  assign w_alarm_cond = avg_valid &&
                        ((avg_temp < TEMP_W'(ALARM_LO)) || (avg_temp > TEMP_W'(ALARM_HI)));

  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset)
      r_alarm <= 1'b0;
    else if (r_eval)
      r_alarm <= w_alarm_cond;
  end

  assign alarm = r_alarm;
`else
  assign w_alarm_cond = 1'b0;
  assign alarm        = 1'b0;
`endif

  // Evaluated one cycle after the tick, once the fresh average is visible.
  always_comb begin
    w_state_nxt = r_state;
    if (r_eval) begin
      if (w_alarm_cond) begin
        w_state_nxt = IDLE;
      end else if (avg_valid && (r_dwell >= DW_W'(MIN_DWELL))) begin
        case (r_state)
          IDLE: begin
            if ((w_avg9 + 9'(HYST)) < w_sp9)
              w_state_nxt = HEAT;
            else if (w_avg9 > (w_sp9 + 9'(HYST)))
              w_state_nxt = COOL;
          end
          HEAT:    if (w_avg9 >= w_sp9) w_state_nxt = IDLE;
          COOL:    if (w_avg9 <= w_sp9) w_state_nxt = IDLE;
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_200kHz or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dwell <= DW_W'(MIN_DWELL);
      heat_on <= 1'b0;
      cool_on <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      heat_on <= (w_state_nxt == HEAT);
      cool_on <= (w_state_nxt == COOL);
      if (w_state_nxt != r_state)
        r_dwell <= '0;
      else if (w_tick && (r_dwell < DW_W'(MIN_DWELL)))
        r_dwell <= r_dwell + DW_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_thermostat_ctrl.sv
// ---------------------------------------------------------------------------
// tb_thermostat_ctrl : scenario tasks plus randomized run against a model
// Revision           : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_thermostat_ctrl;

  localparam int SAMPLE_DIV = 16;
  localparam int MIN_DWELL  = 2;
  localparam int HYST       = 2;
  localparam int SP_DEFAULT = 22;
  localparam int SP_MIN     = 10;
  localparam int SP_MAX     = 35;
  localparam int ALARM_LO   = 5;
  localparam int ALARM_HI   = 45;
  localparam int M_IDLE = 0, M_HEAT = 1, M_COOL = 2;

  logic       clk_200kHz = 1'b0;
  logic       reset      = 1'b0;
  logic [7:0] temp_data  = 8'd0;
  logic       btn_up     = 1'b0;
  logic       btn_dn     = 1'b0;
  logic [7:0] setpoint, avg_temp;
  logic       avg_valid, heat_on, cool_on, alarm;
  logic [19:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  assign dut_vec = {setpoint, avg_temp, avg_valid, heat_on, cool_on, alarm};

  thermostat_ctrl #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .HYST       (HYST),
    .MIN_DWELL  (MIN_DWELL),
    .SP_DEFAULT (SP_DEFAULT),
    .SP_MIN     (SP_MIN),
    .SP_MAX     (SP_MAX)
  ) dut (
    .clk_200kHz (clk_200kHz),
    .reset      (reset),
    .temp_data  (temp_data),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .setpoint   (setpoint),
    .avg_temp   (avg_temp),
    .avg_valid  (avg_valid),
    .heat_on    (heat_on),
    .cool_on    (cool_on),
    .alarm      (alarm)
  );

  always #5 clk_200kHz = ~clk_200kHz;

  // Reference model: a sample window queue, a mode and plain integer rules.
  int       m_phase, m_avg, m_mode, m_dwell, m_sp;
  bit       m_valid, m_alarm, m_eval_due;
  int       m_win[$];
  bit [2:0] m_up_seen, m_dn_seen;

  task automatic model_reset();
    m_phase = 0; m_avg = 0; m_mode = M_IDLE; m_dwell = MIN_DWELL; m_sp = SP_DEFAULT;
    m_valid = 0; m_alarm = 0; m_eval_due = 0; m_up_seen = '0; m_dn_seen = '0;
    m_win.delete();
  endtask

  task automatic model_edge();
    bit tick, up_press, dn_press, forced;
    int nxt, sum;
    tick    = (m_phase == SAMPLE_DIV - 1);
    m_phase = tick ? 0 : m_phase + 1;
    if (m_eval_due) begin
      nxt    = m_mode;
      forced = 0;
`ifdef THERMO_ALARM_EN
      m_alarm = m_valid && (m_avg < ALARM_LO || m_avg > ALARM_HI);
      forced  = m_alarm;
`endif
      if (forced) nxt = M_IDLE;
      else if (m_valid && m_dwell >= MIN_DWELL) begin
        if (m_mode == M_IDLE && m_avg + HYST < m_sp)      nxt = M_HEAT;
        else if (m_mode == M_IDLE && m_avg > m_sp + HYST) nxt = M_COOL;
        else if (m_mode == M_HEAT && m_avg >= m_sp)       nxt = M_IDLE;
        else if (m_mode == M_COOL && m_avg <= m_sp)       nxt = M_IDLE;
      end
      if (nxt != m_mode) begin m_mode = nxt; m_dwell = 0; end
    end
    // A press counts when its level has crossed two sync stages and the edge detector
    up_press = m_up_seen[1] && !m_up_seen[2];
    dn_press = m_dn_seen[1] && !m_dn_seen[2];
    if (up_press && !dn_press && m_sp < SP_MAX) m_sp++;
    else if (dn_press && !up_press && m_sp > SP_MIN) m_sp--;
    m_up_seen = {m_up_seen[1:0], btn_up};
    m_dn_seen = {m_dn_seen[1:0], btn_dn};
    if (tick) begin
      m_win.push_back(int'(temp_data));
      if (m_win.size() > 4) void'(m_win.pop_front());
      if (m_win.size() == 4) begin
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_avg = sum / 4; m_valid = 1;
      end
      if (m_dwell < MIN_DWELL) m_dwell++;
    end
    m_eval_due = tick;
  endtask

  function automatic logic [19:0] model_vec();
    return {8'(m_sp), 8'(m_avg), m_valid, m_mode == M_HEAT, m_mode == M_COOL, m_alarm};
  endfunction

  task automatic step();
    @(posedge clk_200kHz);
    if (reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) step();
    n_cmp++;
    if (dut_vec !== {8'd22, 8'd0, 4'b0000}) begin
      n_bad++; $display("FAIL reset_state got=%h want=%h", dut_vec, {8'd22, 8'd0, 4'b0000});
    end
    reset = 1'b1;
  endtask

  task automatic test_warmup();
    int k = 0;
    temp_data = 8'd20;
    while (!m_valid && k < 200) begin
      step(); k++;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL warmup t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (avg_valid !== 1'b1 || avg_temp !== 8'd20 || heat_on !== 1'b0) begin
      n_bad++; $display("FAIL warmup_final valid=%b avg=%0d heat=%b want 1/20/0", avg_valid, avg_temp, heat_on);
    end
  endtask

  task automatic test_heat();
    temp_data = 8'd18;
    repeat (6 * SAMPLE_DIV) begin
      step(); n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL heat_on t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (heat_on !== 1'b1) begin n_bad++; $display("FAIL heat_rise heat=%b want 1", heat_on); end
    temp_data = 8'd22;
    repeat (8 * SAMPLE_DIV) begin
      step(); n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL heat_off t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (heat_on !== 1'b0) begin n_bad++; $display("FAIL heat_fall heat=%b want 0", heat_on); end
  endtask

  task automatic test_cool();
    temp_data = 8'd30;
    repeat (6 * SAMPLE_DIV) begin
      step(); n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL cool_on t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (cool_on !== 1'b1) begin n_bad++; $display("FAIL cool_rise cool=%b want 1", cool_on); end
    temp_data = 8'd10;
    repeat (10 * SAMPLE_DIV) begin
      step(); n_cmp++;
      if (dut_vec !== model_vec() || (heat_on && cool_on)) begin
        n_bad++; $display("FAIL cool_to_heat t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (cool_on !== 1'b0 || heat_on !== 1'b1) begin
      n_bad++; $display("FAIL cool_final cool=%b heat=%b want 0/1", cool_on, heat_on);
    end
  endtask

  task automatic test_buttons();
    for (int p = 0; p < 51; p++) begin
      btn_up = (p < 20) || (p == 20);
      btn_dn = (p >= 20);
      repeat (4) begin
        step(); n_cmp++;
        if (dut_vec !== model_vec()) begin
          n_bad++; $display("FAIL buttons t=%0t got=%h want=%h", $time, dut_vec, model_vec());
        end
      end
      btn_up = 1'b0; btn_dn = 1'b0;
      repeat (4) step();
      if (p == 19 || p == 20) begin
        n_cmp++;
        if (setpoint !== 8'd35) begin n_bad++; $display("FAIL sp_max pulse=%0d sp=%0d want 35", p, setpoint); end
      end
    end
    n_cmp++;
    if (setpoint !== 8'd10) begin n_bad++; $display("FAIL sp_min sp=%0d want 10", setpoint); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    temp_data = 8'd5;
    while (!heat_on && k < 400) begin
      step(); k++; n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL to_heat t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (heat_on !== 1'b1) begin n_bad++; $display("FAIL reach_heat heat=%b want 1", heat_on); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec !== {8'd22, 8'd0, 4'b0000}) begin
      n_bad++; $display("FAIL async_reset got=%h want=%h", dut_vec, {8'd22, 8'd0, 4'b0000});
    end
    step();
    reset = 1'b1;
  endtask

`ifdef THERMO_ALARM_EN
  task automatic test_alarm();
    int k = 0;
    temp_data = 8'd30;
    while (!cool_on && k < 300) begin
      step(); k++; n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL alarm_pre t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    temp_data = 8'd50; k = 0;
    while (!alarm && k < 300) begin
      step(); k++; n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL alarm_rise t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (alarm !== 1'b1 || cool_on !== 1'b0) begin
      n_bad++; $display("FAIL alarm_idle alarm=%b cool=%b want 1/0", alarm, cool_on);
    end
    temp_data = 8'd30; k = 0;
    while (alarm && k < 300) begin
      step(); k++; n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL alarm_clear t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_off alarm=%b want 0", alarm); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0)
        temp_data = ($urandom_range(0, 3) == 0) ? 8'(255 - $urandom_range(0, 3))
                                                 : 8'($urandom_range(0, 60));
      if ($urandom_range(0, 9) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 9) == 0) btn_dn = ~btn_dn;
      step(); n_cmp++;
      if (dut_vec !== model_vec() || (heat_on && cool_on)) begin
        n_bad++; $display("FAIL random t=%0t got=%h want=%h", $time, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_heat();
    test_cool();
    test_buttons();
    test_reset_mid();
`ifdef THERMO_ALARM_EN
    test_alarm();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
